uart_boot_ctrl: RTL
===================

// Module: uart_boot_ctrl
// PURPOSE
//  Sequences SoC program download over UART. While the prog pad is high, the block:
//  - holds the core in reset;
//  - takes a byte stream from the UART receiver (length header, then little-endian words);
//  - writes the words to instruction memory through a req/gnt port.
//  Sits between the UART receiver, the instruction-memory write port and the core reset, inside the SoC top.
// PARAMETERS
//  BASE_ADDR    32'h0000_0000  byte address of first word written
//  MAX_WORDS    4096           largest legal word count in header
//  TIMEOUT_CYC  1_000_000      max clk cycles between bytes in a download; 0 disables the timeout
// PORTS
//  clk_i        in   1   system clock
//  rst_ni       in   1   asynchronous active-low reset
//  prog_i       in   1   prog pad level, asynchronous; synchronised here by 2 flops
//  rx_valid_i   in   1   1-cycle strobe: rx_data_i holds a received byte
//  rx_data_i    in   8   received byte
//  rx_err_i     in   1   1-cycle strobe: framing error on the received byte
//  mem_req_o    out  1   write request
//  mem_gnt_i    in   1   write accepted this cycle (when mem_req_o=1)
//  mem_addr_o   out  32  byte address, word aligned
//  mem_wdata_o  out  32  write data
//  mem_be_o     out  4   byte enables, always 4'hF when mem_req_o=1
//  core_rst_no  out  1   core reset, active low
//  busy_o       out  1   download in progress (states LEN0..WRITE)
//  done_o       out  1   last download completed without error
//  err_o        out  1   last download failed
//  words_o      out  13  words written so far in the current or last download
// BEHAVIOUR
//  Reset values (all outputs): mem_req_o=0, mem_addr_o=BASE_ADDR, mem_wdata_o=0, mem_be_o=0,
//   core_rst_no=0, busy_o=0, done_o=0, err_o=0, words_o=0. State = BOOT. Sync flops cleared.
//  prog_s = prog_i after 2 flops; prog_rise/prog_fall detected on prog_s vs its previous value.
//  Byte receive = rx_valid_i=1 and rx_err_i=0. A receive with rx_err_i=1 is an error.
//  FSM:
//   BOOT : prog_s=1 -> LEN0; else -> RUN.
//   RUN  : core_rst_no=1. prog_rise -> LEN0.
//          Entering LEN0 from any state: clear done_o, err_o, words_o; addr=BASE_ADDR; core_rst_no=0 same cycle.
//   LEN0 : byte -> len[7:0]; go to LEN1.
//   LEN1 : byte -> len[15:8]. If len=0 -> DONE. If len>MAX_WORDS -> ERR. Else -> DATA, with byte index=0.
//   DATA : byte -> wdata[8*idx +: 8] (LE), idx+1. On 4th byte -> WRITE, with mem_req_o=1 the next cycle.
//   WRITE: hold mem_req_o, addr and wdata stable until mem_gnt_i=1.
//          On gnt: mem_req_o=0 next cycle; addr+=4; words_o+=1. If words_o==len -> DONE, else -> DATA.
//          A gnt in the same cycle as req counts (minimum 1 cycle per write).
//   DONE : done_o=1, core stays in reset. prog_fall -> RUN (core released next cycle).
//   ERR  : err_o=1, core_rst_no=0, no writes issued. Only exit: prog_rise -> LEN0 (retry).
//  Error entries into ERR from LEN0, LEN1, DATA or WRITE:
//   - rx_err_i=1;
//   - any rx_valid_i=1 while in WRITE (overrun);
//   - prog_fall before DONE;
//   - inter-byte timeout: counter cleared on every byte and on LEN0 entry, frozen in WRITE,
//     reaches TIMEOUT_CYC-1.
//   If an error occurs in WRITE while the request is pending, mem_req_o drops next cycle
//   and the write is abandoned; a gnt in that same cycle still counts.
//  Priority within one cycle: rx error/overrun > prog_fall > timeout > normal byte.
//  Bytes received in BOOT, RUN, DONE or ERR are ignored.
//  mem_addr_o wraps modulo 2^32 (unreachable with a legal MAX_WORDS).
//  Async reset mid-download: all state returns to reset values immediately; a pending request is dropped.
//  Header and data bytes are never written beyond len words.
// TESTING
//  1. prog_i=0 through reset -> core_rst_no=1 within 4 cycles of rst_ni rising; no mem_req_o.
//  2. prog high; send 02 00 | 78 56 34 12 | EF BE AD DE; gnt tied 1 -> two writes:
//     (BASE, 32'h12345678), (BASE+4, 32'hDEADBEEF); done_o=1, words_o=2.
//     Then drop prog -> core_rst_no=1.
//  3. Same stream with gnt delayed 5 cycles per write -> req, addr and data held stable 5 cycles; same result.
//  4. Header 00 00 -> done_o=1 with no writes. Header 01 10 (4097 > MAX_WORDS) -> err_o=1, no writes.
//  5. rx_err_i pulse on 3rd data byte -> err_o=1, core_rst_no=0.
//     prog low->high, resend a valid stream -> err_o=0, done_o=1.
//  6. TIMEOUT_CYC=100, stop after 5 bytes -> err_o=1 exactly 100 cycles after the last byte.
//     Separately, rx_valid_i during a pending WRITE -> err_o=1 and mem_req_o drops.

Source files
------------

// File: rtl/uart_boot_ctrl.sv
// uart_boot_ctrl
// Downloads a program image over UART into instruction memory while the prog
// pad is high. Stream format: 16-bit little-endian word count, then that many
// little-endian 32-bit words. The core is held in reset for the whole download
// and released only when prog drops after a successful load.
module uart_boot_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned MAX_WORDS   = 32'd4096,
    parameter int unsigned TIMEOUT_CYC = 32'd1_000_000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        prog_i,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_err_i,
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    output logic        core_rst_no,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [12:0] words_o
);

    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_RUN   = 3'd1,
        ST_LEN0  = 3'd2,
        ST_LEN1  = 3'd3,
        ST_DATA  = 3'd4,
        ST_WRITE = 3'd5,
        ST_DONE  = 3'd6,
        ST_ERR   = 3'd7
    } state_t;

    // Timeout fires when the idle counter sits on this value; unused when disabled.
    localparam bit          TMO_EN   = (TIMEOUT_CYC != 32'd0);
    localparam logic [31:0] TMO_LAST = TMO_EN ? (TIMEOUT_CYC - 32'd1) : 32'd0;

    state_t      state_r;
    state_t      state_nxt_s;

    logic        prog_meta_r;
    logic        prog_sync_r;
    logic        prog_prev_r;

    logic [15:0] len_r;
    logic [1:0]  idx_r;
    logic [31:0] wdata_r;
    logic [31:0] addr_r;
    logic [12:0] words_r;
    logic [31:0] tmo_cnt_r;
    logic        mem_req_r;
    logic [3:0]  mem_be_r;
    logic        core_rst_n_r;
    logic        busy_r;
    logic        done_r;
    logic        err_r;

    logic [15:0] len_nxt_s;
    logic [1:0]  idx_nxt_s;
    logic [31:0] wdata_nxt_s;
    logic [31:0] addr_nxt_s;
    logic [12:0] words_nxt_s;
    logic [31:0] tmo_cnt_nxt_s;
    logic        mem_req_nxt_s;
    logic [3:0]  mem_be_nxt_s;
    logic        core_rst_n_nxt_s;
    logic        busy_nxt_s;
    logic        done_nxt_s;
    logic        err_nxt_s;

    logic        prog_rise_s;
    logic        prog_fall_s;
    logic        byte_s;
    logic        in_dl_s;
    logic        in_rx_phase_s;
    logic        rx_bad_s;
    logic        timeout_s;
    logic        abort_s;
    logic        accept_s;
    logic [15:0] len_full_s;
    logic        len_over_s;
    logic        last_word_s;
    logic        gnt_s;
    logic        enter_len0_s;

    assign prog_rise_s   = prog_sync_r & ~prog_prev_r;
    assign prog_fall_s   = ~prog_sync_r & prog_prev_r;
    assign byte_s        = rx_valid_i & ~rx_err_i;
    assign in_rx_phase_s = (state_r == ST_LEN0) || (state_r == ST_LEN1) || (state_r == ST_DATA);
    assign in_dl_s       = in_rx_phase_s || (state_r == ST_WRITE);
    // Any strobe while a write is pending is an overrun: the byte would be lost.
    assign rx_bad_s      = rx_valid_i & (rx_err_i | (state_r == ST_WRITE));
    assign timeout_s     = TMO_EN && in_rx_phase_s && (tmo_cnt_r == TMO_LAST);
    assign abort_s       = in_dl_s & (rx_bad_s | prog_fall_s | timeout_s);
    assign accept_s      = byte_s & ~abort_s;
    assign len_full_s    = {rx_data_i, len_r[7:0]};
    assign len_over_s    = (32'(len_full_s) > MAX_WORDS);
    assign last_word_s   = (({3'd0, words_r} + 16'd1) == len_r);
    assign gnt_s         = (state_r == ST_WRITE) & mem_gnt_i;
    assign enter_len0_s  = (state_nxt_s == ST_LEN0) && (state_r != ST_LEN0);

    assign mem_req_o   = mem_req_r;
    assign mem_addr_o  = addr_r;
    assign mem_wdata_o = wdata_r;
    assign mem_be_o    = mem_be_r;
    assign core_rst_no = core_rst_n_r;
    assign busy_o      = busy_r;
    assign done_o      = done_r;
    assign err_o       = err_r;
    assign words_o     = words_r;

    // Two-flop synchroniser for the prog pad plus previous value for edge detect.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prog_meta_r <= 1'b0;
            prog_sync_r <= 1'b0;
            prog_prev_r <= 1'b0;
        end else begin
            prog_meta_r <= prog_i;
            prog_sync_r <= prog_meta_r;
            prog_prev_r <= prog_sync_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_BOOT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; errors pre-empt normal byte handling in every download state.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_BOOT: begin
                if (prog_sync_r) state_nxt_s = ST_LEN0;
                else             state_nxt_s = ST_RUN;
            end
            ST_RUN: begin
                if (prog_rise_s) state_nxt_s = ST_LEN0;
                else             state_nxt_s = ST_RUN;
            end
            ST_LEN0: begin
                if (abort_s)     state_nxt_s = ST_ERR;
                else if (byte_s) state_nxt_s = ST_LEN1;
                else             state_nxt_s = ST_LEN0;
            end
            ST_LEN1: begin
                if (abort_s) begin
                    state_nxt_s = ST_ERR;
                end else if (byte_s) begin
                    if (len_full_s == 16'd0) state_nxt_s = ST_DONE;
                    else if (len_over_s)     state_nxt_s = ST_ERR;
                    else                     state_nxt_s = ST_DATA;
                end else begin
                    state_nxt_s = ST_LEN1;
                end
            end
            ST_DATA: begin
                if (abort_s)                         state_nxt_s = ST_ERR;
                else if (byte_s && (idx_r == 2'd3)) state_nxt_s = ST_WRITE;
                else                                 state_nxt_s = ST_DATA;
            end
            ST_WRITE: begin
                if (abort_s) begin
                    state_nxt_s = ST_ERR;
                end else if (mem_gnt_i) begin
                    if (last_word_s) state_nxt_s = ST_DONE;
                    else             state_nxt_s = ST_DATA;
                end else begin
                    state_nxt_s = ST_WRITE;
                end
            end
            ST_DONE: begin
                if (prog_fall_s) state_nxt_s = ST_RUN;
                else             state_nxt_s = ST_DONE;
            end
            ST_ERR: begin
                if (prog_rise_s) state_nxt_s = ST_LEN0;
                else             state_nxt_s = ST_ERR;
            end
            default: begin
                state_nxt_s = ST_BOOT;
            end
        endcase
    end

    // Datapath and output next values; outputs are derived from the next state so they register in step with it.
    always_comb begin
        len_nxt_s     = len_r;
        idx_nxt_s     = idx_r;
        wdata_nxt_s   = wdata_r;
        addr_nxt_s    = addr_r;
        words_nxt_s   = words_r;
        tmo_cnt_nxt_s = tmo_cnt_r;
        done_nxt_s    = done_r;
        err_nxt_s     = err_r;

        if (enter_len0_s) begin
            addr_nxt_s    = BASE_ADDR;
            words_nxt_s   = 13'd0;
            tmo_cnt_nxt_s = 32'd0;
            done_nxt_s    = 1'b0;
            err_nxt_s     = 1'b0;
        end else begin
            case (state_r)
                ST_LEN0: begin
                    if (accept_s) len_nxt_s[7:0] = rx_data_i;
                    else          len_nxt_s      = len_r;
                end
                ST_LEN1: begin
                    if (accept_s) begin
                        len_nxt_s[15:8] = rx_data_i;
                        idx_nxt_s       = 2'd0;
                    end else begin
                        len_nxt_s = len_r;
                    end
                end
                ST_DATA: begin
                    if (accept_s) begin
                        wdata_nxt_s[{idx_r, 3'b000} +: 8] = rx_data_i;
                        idx_nxt_s                         = idx_r + 2'd1;
                    end else begin
                        idx_nxt_s = idx_r;
                    end
                end
                ST_WRITE: begin
                    // A grant coinciding with an abort still completed the write.
                    if (gnt_s) begin
                        addr_nxt_s  = addr_r + 32'd4;
                        words_nxt_s = words_r + 13'd1;
                    end else begin
                        addr_nxt_s = addr_r;
                    end
                end
                default: begin
                    len_nxt_s = len_r;
                end
            endcase

            // Inter-byte idle counter: runs while waiting for bytes, frozen during writes.
            if (in_rx_phase_s) begin
                if (rx_valid_i) tmo_cnt_nxt_s = 32'd0;
                else            tmo_cnt_nxt_s = tmo_cnt_r + 32'd1;
            end else begin
                tmo_cnt_nxt_s = tmo_cnt_r;
            end

            if (state_nxt_s == ST_DONE)     done_nxt_s = 1'b1;
            else                            done_nxt_s = done_r;
            if (state_nxt_s == ST_ERR)      err_nxt_s  = 1'b1;
            else                            err_nxt_s  = err_r;
        end

        mem_req_nxt_s    = (state_nxt_s == ST_WRITE);
        mem_be_nxt_s     = mem_req_nxt_s ? 4'hF : 4'h0;
        core_rst_n_nxt_s = (state_nxt_s == ST_RUN);
        busy_nxt_s       = (state_nxt_s == ST_LEN0) || (state_nxt_s == ST_LEN1) ||
                           (state_nxt_s == ST_DATA) || (state_nxt_s == ST_WRITE);
    end

    // Datapath and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            len_r        <= 16'd0;
            idx_r        <= 2'd0;
            wdata_r      <= 32'd0;
            addr_r       <= BASE_ADDR;
            words_r      <= 13'd0;
            tmo_cnt_r    <= 32'd0;
            mem_req_r    <= 1'b0;
            mem_be_r     <= 4'h0;
            core_rst_n_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            len_r        <= len_nxt_s;
            idx_r        <= idx_nxt_s;
            wdata_r      <= wdata_nxt_s;
            addr_r       <= addr_nxt_s;
            words_r      <= words_nxt_s;
            tmo_cnt_r    <= tmo_cnt_nxt_s;
            mem_req_r    <= mem_req_nxt_s;
            mem_be_r     <= mem_be_nxt_s;
            core_rst_n_r <= core_rst_n_nxt_s;
            busy_r       <= busy_nxt_s;
            done_r       <= done_nxt_s;
            err_r        <= err_nxt_s;
        end
    end

endmodule
